// File: rtl/odd_even_sort_ctrl.sv
// Odd-even transposition sorter: loads NUM words, sorts in NUM single-cycle phases, unloads ascending.
// Latency NUM+1 cycles from last accepted input to first out_valid; out_data holds while out_ready is low.

// Compare-exchange cell: strict unsigned compare, so equal inputs pass straight through.
module sort2 #(
    parameter int DATAWIDTH = 8
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] sme,
    output logic [DATAWIDTH-1:0] big
);
    assign sme = (a > b) ? b : a;
    assign big = (a > b) ? a : b;
endmodule

module odd_even_sort_ctrl #(
    parameter int DATAWIDTH = 8,
    parameter int NUM       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] out_data,
    output logic                 busy
);
    localparam int CNTW = $clog2(NUM + 1);
    localparam int IW   = $clog2(NUM);
    localparam logic [CNTW-1:0] LAST = CNTW'(NUM - 1);

    typedef enum logic [1:0] {LOAD, SORT, UNLOAD} state_t;

    state_t               state_q, state_d;
    logic [CNTW-1:0]      idx_q, idx_d;
    logic [CNTW-1:0]      phase_q, phase_d;
    logic [DATAWIDTH-1:0] arr_q    [NUM];
    logic [DATAWIDTH-1:0] arr_d    [NUM];
    logic [DATAWIDTH-1:0] even_res [NUM];
    logic [DATAWIDTH-1:0] odd_res  [NUM];
    logic [IW-1:0]        idx_sel;

    assign idx_sel = idx_q[IW-1:0];

    for (genvar k = 0; k < NUM / 2; k++) begin : g_even
        sort2 #(.DATAWIDTH(DATAWIDTH)) u_cell (
            .a   (arr_q[2*k]),
            .b   (arr_q[2*k+1]),
            .sme (even_res[2*k]),
            .big (even_res[2*k+1])
        );
    end

    // Odd phases leave the two end words untouched.
    for (genvar k = 0; k < NUM / 2 - 1; k++) begin : g_odd
        sort2 #(.DATAWIDTH(DATAWIDTH)) u_cell (
            .a   (arr_q[2*k+1]),
            .b   (arr_q[2*k+2]),
            .sme (odd_res[2*k+1]),
            .big (odd_res[2*k+2])
        );
    end
    assign odd_res[0]     = arr_q[0];
    assign odd_res[NUM-1] = arr_q[NUM-1];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        phase_d = phase_q;
        arr_d   = arr_q;
        case (state_q)
            LOAD: begin
                if (in_valid) begin
                    arr_d[idx_sel] = in_data;
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        phase_d = '0;
                        state_d = SORT;
                    end else begin
                        idx_d = idx_q + CNTW'(1);
                    end
                end
            end
            SORT: begin
                for (int i = 0; i < NUM; i++) begin
                    arr_d[i] = phase_q[0] ? odd_res[i] : even_res[i];
                end
                phase_d = phase_q + CNTW'(1);
                if (phase_q == LAST) begin
                    idx_d   = '0;
                    state_d = UNLOAD;
                end
            end
            UNLOAD: begin
                if (out_ready) begin
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        idx_d = idx_q + CNTW'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            idx_q   <= '0;
            phase_q <= '0;
            for (int i = 0; i < NUM; i++) begin
                arr_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            arr_q   <= arr_d;
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == UNLOAD);
    assign busy      = (state_q != LOAD);
    assign out_data  = (state_q == UNLOAD) ? arr_q[idx_sel] : '0;
endmodule

// File: tb/tb_odd_even_sort_ctrl.sv
// Bench for odd_even_sort_ctrl: NUM=8 instance under random traffic plus a NUM=2 instance.
module tb_odd_even_sort_ctrl;
    localparam int N = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0] in_data, out_data;
    logic       rst2, in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [7:0] in_data2, out_data2;

    int errors = 0;
    int checks = 0;
    logic [7:0] got_q[$];
    logic [7:0] in_q[$];

    odd_even_sort_ctrl #(.DATAWIDTH(8), .NUM(N)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    odd_even_sort_ctrl #(.DATAWIDTH(8), .NUM(2)) dut2 (
        .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .busy(busy2)
    );

    // Caller is at a negedge; returns at the negedge right after the handshake edge.
    task automatic push(input logic [7:0] d, input int max_gap);
        int n;
        in_valid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout in_ready=%0b required 1", in_ready);
        end
        in_q.push_back(d);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Drains one frame with random out_ready, checking out_data stays put while stalled.
    task automatic pop_frame(input int rdy_pct);
        int n;
        logic stalled;
        logic [7:0] held;
        got_q.delete();
        n = 0;
        stalled = 1'b0;
        held = 8'h00;
        while (got_q.size() < N && n < 2000) begin
            if (out_valid) begin
                if (stalled) begin
                    checks++;
                    if (out_data !== held) begin
                        errors++;
                        $display("FAIL stall_hold out_data=%0d required %0d", out_data, held);
                    end
                end
                out_ready = ($urandom_range(99, 0) < rdy_pct);
                if (out_ready) begin
                    got_q.push_back(out_data);
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = out_data;
                end
            end else begin
                out_ready = 1'($urandom_range(1, 0));
                stalled = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (got_q.size() != N) begin
            errors++;
            $display("FAIL pop_timeout words=%0d required %0d", got_q.size(), N);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rst2 = 1'b1;
        in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        in_valid2 = 1'b0; in_data2 = 8'h00; out_ready2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy, out_data} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset in_ready=%0b out_valid=%0b busy=%0b out_data=%0d required 1 0 0 0",
                     in_ready, out_valid, busy, out_data);
        end
    endtask

    task automatic test_reverse();
        int lat;
        in_q.delete();
        for (int i = 0; i < N; i++) push(8'(N - i), 0);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL reverse_latency cycles=%0d required 9", lat);
        end
        pop_frame(100);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL reverse_word%0d got=%0d required %0d", i,
                         (got_q.size() > i) ? got_q[i] : 8'hxx, i + 1);
            end
        end
    endtask

    task automatic test_duplicates();
        logic [7:0] din [N] = '{255, 0, 3, 3, 255, 0, 128, 3};
        logic [7:0] dexp[N] = '{0, 0, 3, 3, 3, 128, 255, 255};
        int n;
        in_q.delete();
        for (int i = 0; i < N; i++) push(din[i], 0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        n = 0;
        while (!out_valid && n < 40) begin
            checks++;
            if ({in_ready, busy, out_data} !== {1'b0, 1'b1, 8'h00}) begin
                errors++;
                $display("FAIL dup_sort_flags in_ready=%0b busy=%0b out_data=%0d required 0 1 0",
                         in_ready, busy, out_data);
            end
            @(negedge clk);
            n++;
        end
        pop_frame(60);
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== dexp[i]) begin
                errors++;
                $display("FAIL dup_word%0d got=%0d required %0d", i,
                         (got_q.size() > i) ? got_q[i] : 8'hxx, dexp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_q[$];
        for (int f = 0; f < 4; f++) begin
            in_q.delete();
            for (int i = 0; i < N; i++) push(8'($urandom_range(255, 0)), 3);
            exp_q = in_q;
            exp_q.sort();
            pop_frame(40);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_next_frame_ready in_ready=%0b required 1", in_ready);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp_f%0d_word%0d got=%0d required %0d", f, i,
                             (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] sh[N];
        logic [7:0] t;
        int j;
        for (int i = 0; i < 5; i++) push(8'($urandom_range(255, 0)), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL rst_midload flags=%b required 100", {in_ready, out_valid, busy});
        end
        for (int i = 0; i < N; i++) push(8'($urandom_range(255, 0)), 0);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_phase3_busy busy=%0b required 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({in_ready, out_valid, busy, out_data} !== {3'b100, 8'h00}) begin
            errors++;
            $display("FAIL rst_midsort flags=%b out_data=%0d required 100 0",
                     {in_ready, out_valid, busy}, out_data);
        end
        for (int i = 0; i < N; i++) sh[i] = 8'(i + 1);
        for (int i = N - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = sh[i]; sh[i] = sh[j]; sh[j] = t;
        end
        for (int i = 0; i < N; i++) push(sh[i], 1);
        pop_frame(70);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (got_q.size() <= i || got_q[i] !== 8'(i + 1)) begin
                errors++;
                $display("FAIL rst_fresh_word%0d got=%0d required %0d", i,
                         (got_q.size() > i) ? got_q[i] : 8'hxx, i + 1);
            end
        end
    endtask

    task automatic test_num2();
        int lat;
        in_valid2 = 1'b1;
        in_data2  = 8'd9;
        @(negedge clk);
        in_data2  = 8'd4;
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = 1;
        while (!out_valid2 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL num2_latency cycles=%0d required 3", lat);
        end
        out_ready2 = 1'b1;
        checks++;
        if ({out_valid2, out_data2} !== {1'b1, 8'd4}) begin
            errors++;
            $display("FAIL num2_word0 valid=%0b data=%0d required 1 4", out_valid2, out_data2);
        end
        @(negedge clk);
        checks++;
        if ({out_valid2, out_data2} !== {1'b1, 8'd9}) begin
            errors++;
            $display("FAIL num2_word1 valid=%0b data=%0d required 1 9", out_valid2, out_data2);
        end
        @(negedge clk);
        out_ready2 = 1'b0;
        checks++;
        if ({out_valid2, in_ready2, busy2} !== 3'b010) begin
            errors++;
            $display("FAIL num2_back_to_load flags=%b required 010", {out_valid2, in_ready2, busy2});
        end
    endtask

    task automatic test_random_regression();
        logic [7:0] exp_q[$];
        logic [7:0] v;
        for (int f = 0; f < 1000; f++) begin
            in_q.delete();
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(5, 0))
                    0:       v = 8'h00;
                    1:       v = 8'hFF;
                    default: v = 8'($urandom_range(255, 0));
                endcase
                push(v, ($urandom_range(3, 0) == 0) ? 2 : 0);
            end
            exp_q = in_q;
            exp_q.sort();
            pop_frame(75);
            for (int i = 0; i < N; i++) begin
                checks++;
                if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand_f%0d_word%0d got=%0d required %0d", f, i,
                             (got_q.size() > i) ? got_q[i] : 8'hxx, exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_reverse();
        test_duplicates();
        test_backpressure();
        test_reset_midframe();
        test_num2();
        test_random_regression();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end
endmodule
